// File: rtl/ram_read_demux_pkg.sv
// ram_read_demux_pkg: shared destination/FSM enums, default RAM widths and destination priority helper
package ram_read_demux_pkg;
  localparam int RAM_ADDR_W = 16;
  localparam int RAM_DATA_W = 8;
  typedef enum logic [1:0] {DEST_LAYER, DEST_FILE, DEST_COMPRESS} dest_t;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  function automatic dest_t dest_sel(input logic layer, input logic image);
    return layer ? DEST_LAYER : image ? DEST_FILE : DEST_COMPRESS;
  endfunction
endpackage

// File: rtl/ram_read_demux_fifo.sv
// byte_fifo2: 2-entry byte FIFO; ports clk/rst, push/din write, pop, head output, count occupancy
module byte_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/ram_read_demux.sv
// ram_read_demux: streams BaseAddr..+Length from RAM to one of Layer/File/Compress consumers with credit-limited reads
module ram_read_demux
  import ram_read_demux_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Image,
  input  logic              Layer,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Length,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] RamAddr,
  output logic              RamRd,
  input  logic [DATA_W-1:0] RamData,
  output logic [DATA_W-1:0] LayerOutput,
  output logic [DATA_W-1:0] DataOutFile,
  output logic [DATA_W-1:0] DataOutCompress,
  output logic              LayerValid,
  output logic              FileValid,
  output logic              CompressValid,
  input  logic              LayerReady,
  input  logic              FileReady,
  input  logic              CompressReady
);
  state_t state;
  dest_t dest;
  logic [ADDR_W:0] remaining;
  logic in_flight;
  logic [1:0] count;
  logic [DATA_W-1:0] head;
  logic ready, pop, rd_ok;
  always_comb begin
    ready = dest == DEST_LAYER ? LayerReady : dest == DEST_FILE ? FileReady : CompressReady;
    pop = (count != 2'd0) && ready;
    // buffered + in-flight bytes after this cycle's pop must leave room for the new read
    rd_ok = (state == READ) && (3'(count) + 3'(in_flight) - 3'(pop) < 3'd2);
  end
  assign RamRd = rd_ok;
  assign Busy = (state == READ) || (state == DRAIN);
  assign Done = state == FIN;
  assign LayerOutput = head;
  assign DataOutFile = head;
  assign DataOutCompress = head;
  assign LayerValid = (dest == DEST_LAYER) && (count != 2'd0);
  assign FileValid = (dest == DEST_FILE) && (count != 2'd0);
  assign CompressValid = (dest == DEST_COMPRESS) && (count != 2'd0);
  byte_fifo2 #(.W(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_flight),
    .pop(pop),
    .din(RamData),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dest <= DEST_COMPRESS;
      RamAddr <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= rd_ok;
      case (state)
        IDLE: if (Start) begin
          dest <= dest_sel(Layer, Image);
          RamAddr <= BaseAddr;
          remaining <= Length;
          state <= Length == '0 ? FIN : READ;
        end
        READ: if (rd_ok) begin
          RamAddr <= RamAddr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
        end
        DRAIN: if (!in_flight && (count == 2'd0 || (count == 2'd1 && pop))) state <= FIN;
        FIN: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_read_demux.sv
// tb_ram_read_demux: randomized/directed transfers checked against a queue-based byte-order reference
module tb_ram_read_demux;
  logic clk = 1'b0, rst = 1'b1, Start = 1'b0, Image = 1'b0, Layer = 1'b0;
  logic [15:0] BaseAddr = '0;
  logic [16:0] Length = '0;
  logic Busy, Done, RamRd;
  logic [15:0] RamAddr;
  logic [7:0] RamData = '0;
  logic [7:0] LayerOutput, DataOutFile, DataOutCompress;
  logic LayerValid, FileValid, CompressValid;
  logic LayerReady = 1'b0, FileReady = 1'b0, CompressReady = 1'b0;
  logic [7:0] ram [65536];
  int vectors = 0, errors = 0;
  int hs_r;
  always #5 clk = ~clk;
  always @(posedge clk) if (RamRd) RamData <= ram[RamAddr];
  ram_read_demux dut (
    .clk(clk), .rst(rst), .Start(Start), .Image(Image), .Layer(Layer),
    .BaseAddr(BaseAddr), .Length(Length), .Busy(Busy), .Done(Done),
    .RamAddr(RamAddr), .RamRd(RamRd), .RamData(RamData),
    .LayerOutput(LayerOutput), .DataOutFile(DataOutFile), .DataOutCompress(DataOutCompress),
    .LayerValid(LayerValid), .FileValid(FileValid), .CompressValid(CompressValid),
    .LayerReady(LayerReady), .FileReady(FileReady), .CompressReady(CompressReady)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {26'd0, Busy, Done, RamRd, LayerValid, FileValid, CompressValid}, 32'd0);
    check({tag, "_addr"}, {16'd0, RamAddr}, 32'd0);
    check({tag, "_data"}, {8'd0, LayerOutput, DataOutFile, DataOutCompress}, 32'd0);
  endtask
  // mode 0: selected Ready held high, 1: selected Ready toggles, 2: random Ready
  task automatic run_xfer(input logic [15:0] base, input int len, input bit lay, input bit img,
                          input int mode, input bit poke);
    logic [7:0] q[$];
    int hs = 0, issued = 0, done_c = -1, sel;
    bit pv = 0, phs = 0, v, r, rsel;
    logic [7:0] pd = '0, d;
    sel = lay ? 0 : img ? 1 : 2;
    for (int i = 0; i < len; i++) q.push_back(ram[16'(base + 16'(i))]);
    @(negedge clk);
    Start = 1'b1; Layer = lay; Image = img; BaseAddr = base; Length = 17'(len);
    #1 check("idle_busy", {31'd0, Busy}, 32'd0);
    for (int c = 1; c < 200 && done_c < 0; c++) begin
      @(negedge clk);
      Start = poke && c == 2;
      if (Start) begin
        BaseAddr = base ^ 16'h5555; Layer = ~lay; Length = 17'(len + 3);
      end
      rsel = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      LayerReady = sel == 0 ? rsel : 1'($urandom_range(0, 1));
      FileReady = sel == 1 ? rsel : 1'($urandom_range(0, 1));
      CompressReady = sel == 2 ? rsel : 1'($urandom_range(0, 1));
      #1;
      v = sel == 0 ? LayerValid : sel == 1 ? FileValid : CompressValid;
      d = sel == 0 ? LayerOutput : sel == 1 ? DataOutFile : DataOutCompress;
      r = rsel;
      check("other_valid", 32'(int'(LayerValid) + int'(FileValid) + int'(CompressValid) - int'(v)), 32'd0);
      check("busy", {31'd0, Busy}, {31'd0, len != 0 && !Done});
      if (pv && !phs) begin
        check("valid_hold", {31'd0, v}, 32'd1);
        check("data_hold", {24'd0, d}, {24'd0, pd});
      end
      if (mode == 0 && len > 0 && c == 3) check("first_valid", {31'd0, v}, 32'd1);
      if (RamRd) begin
        check("rd_credit", 32'(issued - hs - int'(v && r)), 32'(issued - hs - int'(v && r) < 2 ? issued - hs - int'(v && r) : 1));
        check("rd_addr", {16'd0, RamAddr}, {16'd0, 16'(base + 16'(issued))});
        issued++;
      end
      if (v && r) begin
        if (q.size() == 0) check("extra_byte", 32'(hs + 1), 32'(len));
        else check("data", {24'd0, d}, {24'd0, q.pop_front()});
        hs++;
      end
      pv = v; pd = d; phs = v && r;
      if (Done) done_c = c;
    end
    Start = 1'b0;
    check("done_seen", {31'd0, done_c >= 0}, 32'd1);
    check("hs_count", 32'(hs), 32'(len));
    check("rd_count", 32'(issued), 32'(len));
    if (mode == 0) check("done_cycle", 32'(done_c), 32'(len == 0 ? 1 : len + 3));
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int k = 0; k < 4; k++) ram[16'h0010 + k] = 8'hA0 + 8'(k);
    repeat (2) @(negedge clk);
    #1 check_quiet("reset");
    @(negedge clk); rst = 1'b0;
    run_xfer(16'h0010, 4, 1'b1, 1'b1, 0, 1'b0);
    run_xfer(16'h0200, 5, 1'b0, 1'b1, 1, 1'b0);
    run_xfer(16'hFFFE, 4, 1'b0, 1'b0, 0, 1'b0);
    run_xfer(16'h1234, 0, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    Start = 1'b1; Layer = 1'b0; Image = 1'b0; BaseAddr = 16'h0100; Length = 17'd8;
    CompressReady = 1'b1; LayerReady = 1'b0; FileReady = 1'b0;
    @(negedge clk); Start = 1'b0;
    hs_r = 0;
    for (int c = 1; c < 20 && hs_r < 2; c++) begin
      #1 if (CompressValid && CompressReady) hs_r++;
      @(negedge clk);
    end
    check("rst_pre_hs", 32'(hs_r), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_quiet("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check("post_rst_done", {30'd0, Done, Busy}, 32'd0);
    end
    run_xfer(16'h0300, 6, 1'b0, 1'b0, 0, 1'b0);
    run_xfer(16'h0400, 6, 1'b1, 1'b0, 0, 1'b1);
    run_xfer(16'h0500, 7, 1'b0, 1'b1, 2, 1'b1);
    for (int t = 0; t < 8; t++)
      run_xfer(16'($urandom), $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0);
    run_xfer(16'hFFFA, 10, 1'b0, 1'b0, 2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ram_read_demux.md
# ram_read_demux

Read-side counterpart to the RAM write-path input selector. It streams a contiguous byte region out of the shared image/layer RAM and steers each byte to exactly one consumer: the next CNN layer, the output-file writer, or the compressor. Selection priority matches the write path: Layer over Image over compressed. A 2-entry output buffer with credit-based read issue sustains one byte per cycle under a 1-cycle-latency synchronous RAM and tolerates per-consumer backpressure.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 8, byte width of RAM data and all outputs
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request; sampled only in IDLE
- Image  in  1  destination select, latched at Start
- Layer  in  1  destination select, latched at Start; overrides Image
- BaseAddr  in  ADDR_W  first RAM address, latched at Start
- Length  in  ADDR_W+1  byte count, latched at Start; 0 is legal
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle completion pulse
- RamAddr  out  ADDR_W  RAM read address
- RamRd  out  1  RAM read enable; RamData valid exactly 1 cycle later
- RamData  in  DATA_W  RAM read data
- LayerOutput, DataOutFile, DataOutCompress  out  DATA_W each  consumer data; all carry the buffer head
- LayerValid, FileValid, CompressValid  out  1 each  at most one high at any time
- LayerReady, FileReady, CompressReady  in  1 each  consumer accepts byte when its Valid&Ready

## Operation
- Destination latched at Start: Layer=1 -> LAYER; else Image=1 -> FILE; else COMPRESS. Unselected Valid outputs stay 0; unselected Ready inputs are ignored.
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE: Start=1 latches the inputs. Length=0 -> FIN; otherwise -> READ.
  - READ: issues reads while credit allows. After the read of the last address issues -> DRAIN.
  - DRAIN: waits until the in-flight read has landed, the buffer is empty, and the last byte has been handshaken -> FIN.
  - FIN: Done=1 for one cycle, then -> IDLE.
- Read address is BaseAddr+i for i=0..Length-1, modulo 2^ADDR_W; it wraps from all-ones to 0 silently.
- Credit: a read issues in a cycle only if buffer count + in-flight (0/1) - pop-this-cycle < 2. The buffer never overflows. Under continuous Ready, reads issue every cycle.
- Buffer is a 2-entry FIFO; the head drives all three data outputs. A pop occurs on selected Valid & selected Ready. Simultaneous push and pop is legal at any count.
- Start while not IDLE is ignored: no latch and no effect on the current transfer.
- Bytes are delivered in address order with none dropped or duplicated; exactly Length handshakes occur per transfer.

## Timing
- Reset values: Busy=0, Done=0, RamRd=0, RamAddr=0, all Valid=0, all data outputs=0, FSM=IDLE, buffer empty, in-flight=0.
- Reset mid-transfer: the next cycle is the reset state. No Done pulse. An in-flight RamData is discarded.
- Start sampled in cycle 0:
  - Busy=1 from cycle 1.
  - First RamRd=1 with RamAddr=BaseAddr in cycle 1.
  - Data is captured at the end of cycle 2; Valid=1 in cycle 3.
- Ready held high: one byte accepted per cycle from cycle 3. Last handshake in cycle Length+2. Done=1 in cycle Length+3 with Busy=0 in that same cycle.
- Length=0: Done=1 in cycle 1, Busy stays 0, no RamRd.
- Valid, once high, stays high with stable data until accepted (no retraction).
- Done and Start in the same cycle: Start is ignored; the FSM accepts Start from the following IDLE cycle onward.

## Structure
- Shared package: destination enum (DEST_LAYER, DEST_FILE, DEST_COMPRESS), FSM state enum, and the default ADDR_W/DATA_W constants also used by the write-path selector.
- One sub-module: byte_fifo2 (2-entry FIFO with count, push, pop, head output, synchronous reset). The parent holds the FSM, address/remaining counters, the in-flight flag, and the output steering.

## Test plan
- Layer=1, Image=1, BaseAddr=0x0010, Length=4, RAM[0x10..0x13]=A0..A3, LayerReady=1 -> LayerOutput A0..A3 in cycles 3..6. FileValid and CompressValid stay 0. Done in cycle 7.
- Image=1, Length=5, FileReady toggling 1,0,1,0… -> all 5 bytes arrive in order, Valid never drops while unaccepted, RamRd never issues with 2 bytes outstanding.
- Image=0, Layer=0, BaseAddr=0xFFFE, Length=4 -> CompressValid carries RAM[0xFFFE], [0xFFFF], [0x0000], [0x0001].
- Length=0 -> Done in cycle 1, no RamRd, no Valid, Busy stays 0.
- rst asserted mid-transfer (after 2 of 8 bytes), CompressReady held 1 -> all outputs 0 next cycle, no Done. A fresh Start afterward completes normally.
- Start pulsed during Busy with a different BaseAddr -> ignored; the original transfer completes with its original byte count and destination.
